// File: rtl/interrupt_controller_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | interrupt_controller_if : request/mask/handshake bundle between the       |
// |                           interrupt controller and the processor side.    |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
interface interrupt_controller_if #(
   parameter int NUM_SRC = 4,
   parameter int ID_W    = 2
);
   logic [NUM_SRC-1:0] ext_irq;
   logic               mask_we;
   logic [NUM_SRC-1:0] mask_wdata;
   logic               int_ack;
   logic               rti;
   logic               interrupt;
   logic [ID_W-1:0]    int_id;
   logic               in_service;
   logic [NUM_SRC-1:0] pending;
   logic [NUM_SRC-1:0] mask;

   modport master (
      output ext_irq, mask_we, mask_wdata, int_ack, rti,
      input  interrupt, int_id, in_service, pending, mask
   );

   modport slave (
      input  ext_irq, mask_we, mask_wdata, int_ack, rti,
      output interrupt, int_id, in_service, pending, mask
   );
endinterface
`default_nettype wire

// File: rtl/interrupt_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | interrupt_controller : synchronise, edge-detect, mask and prioritise      |
// |                        external requests into one non-nesting interrupt.  |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module interrupt_controller #(
   parameter int NUM_SRC = 4,
   parameter int ID_W    = 2
) (
   input  wire                   clk,
   input  wire                   rst,
   interrupt_controller_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_SERV = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;

   logic [NUM_SRC-1:0] r_s1;
   logic [NUM_SRC-1:0] r_s2;
   logic [NUM_SRC-1:0] r_s3;
   logic [NUM_SRC-1:0] r_pending;
   logic [NUM_SRC-1:0] r_mask;
   logic               r_interrupt;
   logic               r_in_service;
   logic [ID_W-1:0]    r_int_id;

   logic [NUM_SRC-1:0] w_edge;
   logic [NUM_SRC-1:0] w_clr;
   logic [NUM_SRC-1:0] w_pending_nxt;
   logic [NUM_SRC-1:0] w_eligible;
   logic               w_any;
   logic [ID_W-1:0]    w_winner;
   logic               w_interrupt_nxt;
   logic               w_in_service_nxt;
   logic [ID_W-1:0]    w_int_id_nxt;
   logic               w_ack_taken;

   assign w_edge      = r_s2 & ~r_s3;
   assign w_ack_taken = (r_state == ST_REQ) && bus.int_ack;
   assign w_clr       = w_ack_taken ? (NUM_SRC'(1) << r_int_id) : '0;
   // Set is OR-ed in after the clear so a coincident new edge survives the ack.
   assign w_pending_nxt = (r_pending & ~w_clr) | w_edge;
   assign w_eligible    = r_pending & ~r_mask;
   assign w_any         = |w_eligible;

   always_comb begin
      w_winner = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (w_eligible[i]) begin
            w_winner = ID_W'(i);
         end
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_interrupt_nxt  = r_interrupt;
      w_in_service_nxt = r_in_service;
      w_int_id_nxt     = r_int_id;
      case (r_state)
         ST_IDLE: begin
            if (w_any) begin
               w_int_id_nxt    = w_winner;
               w_interrupt_nxt = 1'b1;
               w_state_nxt     = ST_REQ;
            end
         end
         ST_REQ: begin
            if (bus.int_ack) begin
               w_interrupt_nxt  = 1'b0;
               w_in_service_nxt = 1'b1;
               w_state_nxt      = ST_SERV;
            end
         end
         ST_SERV: begin
            if (bus.rti) begin
               w_in_service_nxt = 1'b0;
               w_state_nxt      = ST_IDLE;
            end
         end
         default: begin
            w_interrupt_nxt  = 1'b0;
            w_in_service_nxt = 1'b0;
            w_state_nxt      = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= ST_IDLE;
         r_interrupt  <= 1'b0;
         r_in_service <= 1'b0;
         r_int_id     <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_interrupt  <= w_interrupt_nxt;
         r_in_service <= w_in_service_nxt;
         r_int_id     <= w_int_id_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_s1      <= '0;
         r_s2      <= '0;
         r_s3      <= '0;
         r_pending <= '0;
         r_mask    <= '0;
      end else begin
         r_s1      <= bus.ext_irq;
         r_s2      <= r_s1;
         r_s3      <= r_s2;
         r_pending <= w_pending_nxt;
         if (bus.mask_we) begin
            r_mask <= bus.mask_wdata;
         end
      end
   end

   assign bus.interrupt  = r_interrupt;
   assign bus.in_service = r_in_service;
   assign bus.int_id     = r_int_id;
   assign bus.pending    = r_pending;
   assign bus.mask       = r_mask;

endmodule
`default_nettype wire

// File: tb/tb_interrupt_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_interrupt_controller : directed self-checking bench for the interrupt  |
// |                           controller.                                    |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_interrupt_controller;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   interrupt_controller_if #(.NUM_SRC(4), .ID_W(2)) bus ();

   interrupt_controller #(.NUM_SRC(4), .ID_W(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   // Advance n rising edges and land 1 time unit after the last one.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_src(input logic [3:0] src);
      bus.ext_irq = src;
      tick(3);
      bus.ext_irq = 4'b0000;
   endtask

   task automatic do_ack;
      bus.int_ack = 1'b1;
      tick(1);
      bus.int_ack = 1'b0;
   endtask

   task automatic do_rti;
      bus.rti = 1'b1;
      tick(1);
      bus.rti = 1'b0;
   endtask

   task automatic test_reset;
      rst            = 1'b0;
      bus.ext_irq    = 4'b0000;
      bus.mask_we    = 1'b0;
      bus.mask_wdata = 4'b0000;
      bus.int_ack    = 1'b0;
      bus.rti        = 1'b0;
      tick(2);
      n_checks++;
      if ({bus.interrupt, bus.in_service, bus.int_id, bus.pending, bus.mask} !== 12'h000) begin
         n_fail++;
         $display("FAIL reset_state: got %b, expected all zero",
                  {bus.interrupt, bus.in_service, bus.int_id, bus.pending, bus.mask});
      end
      rst = 1'b1;
      tick(2);
   endtask

   task automatic test_single_source;
      pulse_src(4'b0100);
      n_checks++;
      if (bus.pending !== 4'b0100) begin
         n_fail++;
         $display("FAIL single_pending: got %b, expected 0100", bus.pending);
      end
      tick(1);
      n_checks++;
      if (bus.interrupt !== 1'b1 || bus.int_id !== 2'd2) begin
         n_fail++;
         $display("FAIL single_request: got irq=%b id=%0d, expected irq=1 id=2", bus.interrupt, bus.int_id);
      end
      do_ack();
      n_checks++;
      if (bus.interrupt !== 1'b0 || bus.in_service !== 1'b1 || bus.pending !== 4'b0000) begin
         n_fail++;
         $display("FAIL single_ack: got irq=%b srv=%b pend=%b, expected irq=0 srv=1 pend=0000",
                  bus.interrupt, bus.in_service, bus.pending);
      end
      do_rti();
      n_checks++;
      if (bus.in_service !== 1'b0 || bus.interrupt !== 1'b0) begin
         n_fail++;
         $display("FAIL single_rti: got srv=%b irq=%b, expected srv=0 irq=0", bus.in_service, bus.interrupt);
      end
   endtask

   task automatic test_priority;
      pulse_src(4'b1010);
      tick(1);
      n_checks++;
      if (bus.interrupt !== 1'b1 || bus.int_id !== 2'd1) begin
         n_fail++;
         $display("FAIL prio_winner: got irq=%b id=%0d, expected irq=1 id=1", bus.interrupt, bus.int_id);
      end
      pulse_src(4'b0001);
      n_checks++;
      if (bus.int_id !== 2'd1 || bus.interrupt !== 1'b1 || bus.pending !== 4'b1011) begin
         n_fail++;
         $display("FAIL prio_frozen: got id=%0d irq=%b pend=%b, expected id=1 irq=1 pend=1011",
                  bus.int_id, bus.interrupt, bus.pending);
      end
      do_ack();
      n_checks++;
      if (bus.pending !== 4'b1001) begin
         n_fail++;
         $display("FAIL prio_ack_clear: got %b, expected 1001", bus.pending);
      end
      do_rti();
      n_checks++;
      if (bus.interrupt !== 1'b0 || bus.in_service !== 1'b0) begin
         n_fail++;
         $display("FAIL prio_idle_gap: got irq=%b srv=%b, expected irq=0 srv=0", bus.interrupt, bus.in_service);
      end
      tick(1);
      n_checks++;
      if (bus.interrupt !== 1'b1 || bus.int_id !== 2'd0) begin
         n_fail++;
         $display("FAIL prio_second: got irq=%b id=%0d, expected irq=1 id=0", bus.interrupt, bus.int_id);
      end
      do_ack();
      do_rti();
      tick(1);
      n_checks++;
      if (bus.interrupt !== 1'b1 || bus.int_id !== 2'd3) begin
         n_fail++;
         $display("FAIL prio_third: got irq=%b id=%0d, expected irq=1 id=3", bus.interrupt, bus.int_id);
      end
      do_ack();
      do_rti();
      n_checks++;
      if (bus.pending !== 4'b0000 || bus.in_service !== 1'b0) begin
         n_fail++;
         $display("FAIL prio_drained: got pend=%b srv=%b, expected pend=0000 srv=0", bus.pending, bus.in_service);
      end
   endtask

   task automatic test_masking;
      bus.mask_we    = 1'b1;
      bus.mask_wdata = 4'b1111;
      tick(1);
      bus.mask_we    = 1'b0;
      n_checks++;
      if (bus.mask !== 4'b1111) begin
         n_fail++;
         $display("FAIL mask_write: got %b, expected 1111", bus.mask);
      end
      pulse_src(4'b0010);
      tick(2);
      n_checks++;
      if (bus.pending !== 4'b0010 || bus.interrupt !== 1'b0) begin
         n_fail++;
         $display("FAIL mask_hold: got pend=%b irq=%b, expected pend=0010 irq=0", bus.pending, bus.interrupt);
      end
      bus.mask_we    = 1'b1;
      bus.mask_wdata = 4'b0000;
      tick(1);
      bus.mask_we    = 1'b0;
      n_checks++;
      if (bus.mask !== 4'b0000 || bus.interrupt !== 1'b0) begin
         n_fail++;
         $display("FAIL unmask_edge: got mask=%b irq=%b, expected mask=0000 irq=0", bus.mask, bus.interrupt);
      end
      tick(1);
      n_checks++;
      if (bus.interrupt !== 1'b1 || bus.int_id !== 2'd1) begin
         n_fail++;
         $display("FAIL unmask_request: got irq=%b id=%0d, expected irq=1 id=1", bus.interrupt, bus.int_id);
      end
   endtask

   // Entered in REQ for id 1 from the masking test.
   task automatic test_stray_handshakes;
      do_rti();
      n_checks++;
      if (bus.interrupt !== 1'b1 || bus.in_service !== 1'b0 || bus.int_id !== 2'd1 || bus.pending !== 4'b0010) begin
         n_fail++;
         $display("FAIL stray_rti: got irq=%b srv=%b id=%0d pend=%b, expected irq=1 srv=0 id=1 pend=0010",
                  bus.interrupt, bus.in_service, bus.int_id, bus.pending);
      end
      do_ack();
      do_rti();
      do_ack();
      n_checks++;
      if (bus.interrupt !== 1'b0 || bus.in_service !== 1'b0 || bus.pending !== 4'b0000) begin
         n_fail++;
         $display("FAIL stray_ack: got irq=%b srv=%b pend=%b, expected irq=0 srv=0 pend=0000",
                  bus.interrupt, bus.in_service, bus.pending);
      end
      tick(1);
      n_checks++;
      if (bus.in_service !== 1'b0 || bus.interrupt !== 1'b0) begin
         n_fail++;
         $display("FAIL stray_ack_settle: got srv=%b irq=%b, expected srv=0 irq=0", bus.in_service, bus.interrupt);
      end
   endtask

   task automatic test_set_wins;
      pulse_src(4'b0010);
      tick(4);
      n_checks++;
      if (bus.interrupt !== 1'b1 || bus.int_id !== 2'd1) begin
         n_fail++;
         $display("FAIL collide_req: got irq=%b id=%0d, expected irq=1 id=1", bus.interrupt, bus.int_id);
      end
      // New edge reaches pending on the third edge, the same one that samples the ack.
      bus.ext_irq = 4'b0010;
      tick(2);
      bus.int_ack = 1'b1;
      tick(1);
      bus.int_ack = 1'b0;
      bus.ext_irq = 4'b0000;
      n_checks++;
      if (bus.pending !== 4'b0010 || bus.in_service !== 1'b1 || bus.interrupt !== 1'b0) begin
         n_fail++;
         $display("FAIL collide_set_wins: got pend=%b srv=%b irq=%b, expected pend=0010 srv=1 irq=0",
                  bus.pending, bus.in_service, bus.interrupt);
      end
      do_rti();
      tick(1);
      n_checks++;
      if (bus.interrupt !== 1'b1 || bus.int_id !== 2'd1) begin
         n_fail++;
         $display("FAIL collide_reserve: got irq=%b id=%0d, expected irq=1 id=1", bus.interrupt, bus.int_id);
      end
      do_ack();
      do_rti();
   endtask

   task automatic test_reset_mid_req;
      bus.mask_we    = 1'b1;
      bus.mask_wdata = 4'b1000;
      tick(1);
      bus.mask_we    = 1'b0;
      pulse_src(4'b1001);
      tick(1);
      n_checks++;
      if (bus.interrupt !== 1'b1 || bus.int_id !== 2'd0 || bus.pending !== 4'b1001) begin
         n_fail++;
         $display("FAIL pre_reset_req: got irq=%b id=%0d pend=%b, expected irq=1 id=0 pend=1001",
                  bus.interrupt, bus.int_id, bus.pending);
      end
      #2;
      rst = 1'b0;
      #1;
      n_checks++;
      if ({bus.interrupt, bus.in_service, bus.int_id, bus.pending, bus.mask} !== 12'h000) begin
         n_fail++;
         $display("FAIL async_reset: got %b, expected all zero",
                  {bus.interrupt, bus.in_service, bus.int_id, bus.pending, bus.mask});
      end
      tick(1);
      rst = 1'b1;
      tick(3);
      n_checks++;
      if (bus.interrupt !== 1'b0 || bus.pending !== 4'b0000) begin
         n_fail++;
         $display("FAIL post_reset_idle: got irq=%b pend=%b, expected irq=0 pend=0000", bus.interrupt, bus.pending);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_single_source();
      test_priority();
      test_masking();
      test_stray_handshakes();
      test_set_wins();
      test_reset_mid_req();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/interrupt_controller.md
# interrupt_controller

Multi-source interrupt front end feeding the single `interrupt` input of the five-stage pipeline processor. It synchronises asynchronous external requests, edge-detects and latches them as pending, applies a software mask, and selects the highest-priority source (lowest index). It then holds a request to the processor until acknowledged and blocks further requests until return-from-interrupt. Nesting is not supported: one interrupt in service at a time.

## Interface

Parameters:
- `NUM_SRC`, default 4: number of external sources, 2..16.
- `ID_W`, default 2: width of the vector id. Must equal clog2(`NUM_SRC`).

Ports:
- `clk`  input  1: processor clock; all state updates on the rising edge.
- `rst`  input  1: reset, asynchronous, active-low. Clears all state immediately.
- `ext_irq`  input  `NUM_SRC`: asynchronous external requests. Active on a rising edge.
- `mask_we`  input  1: write strobe for the mask register.
- `mask_wdata`  input  `NUM_SRC`: new mask value. Bit=1 masks that source.
- `int_ack`  input  1: one-cycle pulse from the processor when it has taken the interrupt.
- `rti`  input  1: one-cycle pulse when the processor retires return-from-interrupt.
- `interrupt`  output  1: request to the processor, registered.
- `int_id`  output  `ID_W`: id of the requested or in-service source. Valid while `interrupt` or `in_service` is high.
- `in_service`  output  1: high from ack until rti.
- `pending`  output  `NUM_SRC`: pending register, for debug/readback.
- `mask`  output  `NUM_SRC`: current mask register.

## Operation

- Synchroniser: per source, `s1`←`ext_irq`, `s2`←`s1`, `s3`←`s2`. `edge[i] = s2[i] & ~s3[i]`.
- Pending: `pending[i]` sets when `edge[i]` is high. It clears when `int_ack` is accepted and `i == int_id`. If set and clear hit the same bit in the same cycle, set wins.
- Mask: on `mask_we`, `mask` ← `mask_wdata` at the next edge. Masked sources still latch pending; they only become eligible once unmasked.
- Eligible vector: `pending & ~mask`. Winner = lowest set index.
- FSM states and transitions:
  - IDLE: `interrupt`=0, `in_service`=0. If any eligible bit is set, latch the winner into `int_id`, set `interrupt`=1, go REQ.
  - REQ: `interrupt` held at 1. `int_id` is frozen, even if the source is masked or a higher-priority source arrives. On `int_ack`: clear the pending bit of `int_id`, `interrupt`←0, `in_service`←1, go SERV.
  - SERV: `in_service`=1, `int_id` held. New edges keep latching into pending. On `rti`: `in_service`←0, go IDLE.
- Ignored inputs:
  - `int_ack` in IDLE or SERV.
  - `rti` in IDLE or REQ.
- `int_ack` and `rti` high together: each is evaluated against the current state only.
- Reset values (async, immediate):
  - `s1`/`s2`/`s3`, `pending` and `mask` = 0, so all sources are unmasked.
  - `interrupt`=0, `in_service`=0, `int_id`=0, state=IDLE.
- Reset mid-REQ or mid-SERV: returns to IDLE and discards all pending requests.
- A source held high produces one pending event only. It must fall and rise again to re-trigger.

## Timing

- Source latency: `ext_irq[i]` sampled high first at edge k. Then `s2`=1 after k+1, `pending[i]`=1 after k+2, `interrupt`=1 after k+3 (in IDLE, unmasked).
- Unmask latency: a pending source that becomes unmasked by a write at edge k raises `interrupt` after k+1.
- Ack: `int_ack` sampled at edge a. `interrupt`=0 and `in_service`=1 after a; pending bit cleared after a.
- RTI: `rti` sampled at edge r. `in_service`=0 after r. If another eligible source is pending, `interrupt`=1 after r+1, since IDLE spends one cycle.
- Minimum ext_irq pulse width: 2 clk periods, high and low, for guaranteed capture.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan

- Reset: drive `rst`=0 mid-cycle while in REQ. `interrupt`, `in_service`, `pending` and `mask` go to 0 immediately, with no clock edge needed.
- Single source:
  - Pulse `ext_irq[2]` for 3 cycles. `pending`=4'b0100 two edges later, then `interrupt`=1 with `int_id`=2.
  - Ack: `interrupt`=0, `in_service`=1, `pending`=0.
  - `rti`: `in_service`=0.
- Priority and frozen id:
  - Raise sources 3 and 1 together. `int_id`=1.
  - In REQ, raise source 0. `int_id` stays 1.
  - After ack and rti, `interrupt` re-asserts with `int_id`=0. Then source 3 is served.
- Masking:
  - Write `mask`=4'b1111, then pulse source 1. `pending[1]`=1 and `interrupt` stays 0.
  - Write `mask`=0. `interrupt`=1 one edge later with `int_id`=1.
- Stray handshakes: `int_ack` in IDLE and `rti` in REQ leave state and outputs unchanged.
- Set-wins collision: a new `ext_irq[1]` edge reaches pending on the same edge as `int_ack` for id 1. `pending[1]` remains 1, and id 1 is served again after rti.
